// File: rtl/flux_gen_pkg.sv
// ---------------------------------------------------------------------------
// flux_gen_pkg
// Shared definitions for the flux pattern generator and its LFSR helper:
// interval mode encodings, controller state enum, LFSR tap mask, the default
// minimum interval, and a single-step Galois LFSR function.
// ---------------------------------------------------------------------------
package flux_gen_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_MFM   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Galois form of x^16+x^14+x^13+x^11+1 for a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned DEFAULT_MIN_WIDTH = 2;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/flux_pattern_generator_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR with synchronous seed load and step enable.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset (state returns to SEED)
//   load    - reload SEED (wins over step)
//   step    - advance one position
//   state   - current register value
// ---------------------------------------------------------------------------
module lfsr16
  import flux_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/flux_pattern_generator.sv
// ---------------------------------------------------------------------------
// flux_pattern_generator
// Loopback stimulus source: emits a toggling data stream whose edge-to-edge
// intervals are fixed or MFM-like, with periodic runt and gap intervals and
// optional LFSR jitter on nominal intervals.
// Ports:
//   clk, reset_n           - HDD-domain clock, async active-low reset
//   enable                 - freezes all state when low (abort still acts)
//   start / abort          - run control (abort wins)
//   mode, base_width       - nominal interval selection
//   jitter_bits            - width of LFSR jitter added to nominal intervals
//   runt_every/runt_width  - every Nth interval replaced by a runt
//   gap_every/gap_width    - every Nth interval replaced by a long gap
//   pulse_limit            - toggles to emit (0 = run forever)
//   data_out, busy, done   - stream and status
//   pulses_sent, runts_sent, gaps_sent - saturating statistics
// ---------------------------------------------------------------------------
module flux_pattern_generator
  import flux_gen_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MIN_WIDTH = DEFAULT_MIN_WIDTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start,
  input  logic        abort,
  input  logic        mode,
  input  logic [15:0] base_width,
  input  logic [2:0]  jitter_bits,
  input  logic [7:0]  runt_every,
  input  logic [15:0] runt_width,
  input  logic [7:0]  gap_every,
  input  logic [15:0] gap_width,
  input  logic [15:0] pulse_limit,
  output logic        data_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] pulses_sent,
  output logic [7:0]  runts_sent,
  output logic [7:0]  gaps_sent
);

  localparam logic [15:0] MIN_W = 16'(MIN_WIDTH);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        data_q, data_d;
  logic        done_q, done_d;
  logic [15:0] pulses_q, pulses_d;
  logic [7:0]  runts_q, runts_d;
  logic [7:0]  gaps_q, gaps_d;
  logic [7:0]  gap_left_q, gap_left_d;
  logic [7:0]  runt_left_q, runt_left_d;

  logic [15:0] lfsr;
  logic        lfsr_load;
  logic        lfsr_step;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .state   (lfsr)
  );

  // Interval for the current pulse index. The runt modulo counter advances on
  // every index even when a gap overrides it, so runts stay index-aligned.
  logic        gap_due, runt_hit, runt_due;
  logic [17:0] base18, nominal;
  logic [7:0]  jit_mask;
  logic [18:0] nominal_jit;
  logic [15:0] w_raw, w_next;

  always_comb begin
    gap_due  = (gap_every != 8'd0) && (gap_left_q == 8'd1);
    runt_hit = (runt_every != 8'd0) && (runt_left_q == 8'd1);
    runt_due = runt_hit && !gap_due;

    base18 = {2'b00, base_width};
    if (mode == MODE_MFM) begin
      case (lfsr[1:0])
        2'b00:   nominal = base18 << 1;
        2'b10:   nominal = base18 << 2;
        default: nominal = (base18 << 1) + base18;
      endcase
    end else begin
      nominal = base18;
    end

    // A 3-bit field cannot exceed 7, so the mask tops out at 7 bits
    jit_mask    = 8'hFF >> (4'd8 - {1'b0, jitter_bits});
    nominal_jit = {1'b0, nominal} + {11'd0, lfsr[15:8] & jit_mask};

    if (gap_due) begin
      w_raw = gap_width;
    end else if (runt_due) begin
      w_raw = runt_width;
    end else if (nominal_jit > 19'h0FFFF) begin
      w_raw = 16'hFFFF;
    end else begin
      w_raw = nominal_jit[15:0];
    end

    w_next = (w_raw < MIN_W) ? MIN_W : w_raw;
  end

  // Control: start/abort handling, interval countdown and toggle bookkeeping
  logic        take_interval;
  logic [15:0] pulses_inc;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    done_d        = done_q;
    pulses_d      = pulses_q;
    runts_d       = runts_q;
    gaps_d        = gaps_q;
    gap_left_d    = gap_left_q;
    runt_left_d   = runt_left_q;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    take_interval = 1'b0;
    pulses_inc    = (pulses_q == 16'hFFFF) ? pulses_q : pulses_q + 16'd1;

    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (enable) begin
      done_d = 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d     = LOAD;
            pulses_d    = 16'd0;
            runts_d     = 8'd0;
            gaps_d      = 8'd0;
            gap_left_d  = gap_every;
            runt_left_d = runt_every;
            lfsr_load   = 1'b1;
          end
        end
        LOAD: begin
          state_d       = RUN;
          take_interval = 1'b1;
        end
        RUN: begin
          if (cnt_q <= 16'd1) begin
            data_d   = ~data_q;
            pulses_d = pulses_inc;
            if ((pulse_limit != 16'd0) && (pulses_inc == pulse_limit)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              take_interval = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (take_interval) begin
        cnt_d       = w_next;
        lfsr_step   = 1'b1;
        gap_left_d  = (gap_left_q <= 8'd1) ? gap_every : gap_left_q - 8'd1;
        runt_left_d = (runt_left_q <= 8'd1) ? runt_every : runt_left_q - 8'd1;
        if (gap_due && (gaps_q != 8'hFF)) begin
          gaps_d = gaps_q + 8'd1;
        end
        if (runt_due && (runts_q != 8'hFF)) begin
          runts_d = runts_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      data_q      <= 1'b0;
      done_q      <= 1'b0;
      pulses_q    <= 16'd0;
      runts_q     <= 8'd0;
      gaps_q      <= 8'd0;
      gap_left_q  <= 8'd0;
      runt_left_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      done_q      <= done_d;
      pulses_q    <= pulses_d;
      runts_q     <= runts_d;
      gaps_q      <= gaps_d;
      gap_left_q  <= gap_left_d;
      runt_left_q <= runt_left_d;
    end
  end

  assign data_out    = data_q;
  assign busy        = (state_q == LOAD) || (state_q == RUN);
  assign done        = done_q;
  assign pulses_sent = pulses_q;
  assign runts_sent  = runts_q;
  assign gaps_sent   = gaps_q;

endmodule

// File: tb/tb_flux_pattern_generator.sv
// Directed self-checking bench for flux_pattern_generator. Expected intervals
// are hand-computed, including the LFSR sequence from seed 16'hACE1:
// ACE1 -> E270 -> 7138 -> 389C -> 1C4E.
module tb_flux_pattern_generator;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic        abort;
  logic        mode;
  logic [15:0] base_width;
  logic [2:0]  jitter_bits;
  logic [7:0]  runt_every;
  logic [15:0] runt_width;
  logic [7:0]  gap_every;
  logic [15:0] gap_width;
  logic [15:0] pulse_limit;
  logic        data_out;
  logic        busy;
  logic        done;
  logic [15:0] pulses_sent;
  logic [7:0]  runts_sent;
  logic [7:0]  gaps_sent;

  int compared   = 0;
  int mismatched = 0;
  int expq[$];

  flux_pattern_generator dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .base_width  (base_width),
    .jitter_bits (jitter_bits),
    .runt_every  (runt_every),
    .runt_width  (runt_width),
    .gap_every   (gap_every),
    .gap_width   (gap_width),
    .pulse_limit (pulse_limit),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent),
    .runts_sent  (runts_sent),
    .gaps_sent   (gaps_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setConfig(input logic m, input logic [15:0] base, input logic [2:0] jb,
                           input logic [7:0] re, input logic [15:0] rw,
                           input logic [7:0] ge, input logic [15:0] gw,
                           input logic [15:0] lim);
    mode = m; base_width = base; jitter_bits = jb;
    runt_every = re; runt_width = rw; gap_every = ge; gap_width = gw;
    pulse_limit = lim;
  endtask

  // One-cycle start pulse; returns 1 time unit after the sampling edge
  task automatic applyStimulus();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until data_out changes; 0 means the bound expired
  task automatic measureInterval(output logic [31:0] cycles);
    logic prev;
    prev   = data_out;
    cycles = 0;
    for (int i = 1; i <= 70000; i++) begin
      @(posedge clk);
      #1;
      if (data_out !== prev) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic checkIntervals(input string tag);
    logic [31:0] cyc;
    for (int i = 0; i < expq.size(); i++) begin
      measureInterval(cyc);
      checkOutput($sformatf("%s_w%0d", tag, i + 1), cyc, expq[i]);
    end
  endtask

  task automatic checkDone(input string tag, input int pulses, input logic level);
    checkOutput({tag, "_done_hi"}, done, 1);
    checkOutput({tag, "_busy_lo"}, busy, 0);
    checkOutput({tag, "_pulses"}, pulses_sent, pulses);
    checkOutput({tag, "_level"}, data_out, level);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_lo"}, done, 0);
  endtask

  initial begin
    logic [31:0] cyc;
    reset_n = 1'b0; enable = 1'b1; start = 1'b0; abort = 1'b0;
    setConfig(1'b0, 16'd150, 3'd0, 8'd0, 16'd0, 8'd0, 16'd0, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pulses", pulses_sent, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] fixed interval, limit 4");
    applyStimulus();
    checkOutput("fix_busy", busy, 1);
    expq = '{151, 150, 150, 150};
    checkIntervals("fix");
    checkDone("fix", 4, 1'b0);

    $display("[TB] runt every 3");
    setConfig(1'b0, 16'd150, 3'd0, 8'd3, 16'd10, 8'd0, 16'd0, 16'd6);
    applyStimulus();
    expq = '{151, 150, 10, 150, 150, 10};
    checkIntervals("runt");
    checkOutput("runt_count", runts_sent, 2);
    checkDone("runt", 6, 1'b0);

    $display("[TB] gap beats runt");
    setConfig(1'b0, 16'd150, 3'd0, 8'd2, 16'd10, 8'd2, 16'd500, 16'd4);
    applyStimulus();
    expq = '{151, 500, 150, 500};
    checkIntervals("gap");
    checkOutput("gap_count", gaps_sent, 2);
    checkOutput("gap_runts", runts_sent, 0);
    checkDone("gap", 4, 1'b0);

    $display("[TB] MFM mode, no jitter");
    setConfig(1'b1, 16'd100, 3'd0, 8'd0, 16'd0, 8'd0, 16'd0, 16'd5);
    applyStimulus();
    expq = '{301, 200, 200, 200, 400};
    checkIntervals("mfm");
    checkDone("mfm", 5, 1'b1);

    $display("[TB] MFM mode, jitter 3");
    setConfig(1'b1, 16'd100, 3'd3, 8'd0, 16'd0, 8'd0, 16'd0, 16'd5);
    applyStimulus();
    expq = '{305, 202, 201, 200, 404};
    checkIntervals("jit");
    checkDone("jit", 5, 1'b0);

    $display("[TB] clamp to minimum width");
    setConfig(1'b0, 16'd1, 3'd0, 8'd0, 16'd0, 8'd0, 16'd0, 16'd3);
    applyStimulus();
    expq = '{3, 2, 2};
    checkIntervals("clamp");
    checkDone("clamp", 3, 1'b1);

    $display("[TB] MFM saturation");
    setConfig(1'b1, 16'hFFFF, 3'd0, 8'd0, 16'd0, 8'd0, 16'd0, 16'd1);
    applyStimulus();
    expq = '{65536};
    checkIntervals("sat");
    checkDone("sat", 1, 1'b0);

    $display("[TB] start while busy, then abort with start");
    setConfig(1'b0, 16'd150, 3'd0, 8'd0, 16'd0, 8'd0, 16'd0, 16'd0);
    applyStimulus();
    measureInterval(cyc);
    checkOutput("ign_w1", cyc, 151);
    repeat (50) @(posedge clk);
    #1;
    applyStimulus();
    checkOutput("ign_busy", busy, 1);
    checkOutput("ign_pulses", pulses_sent, 1);
    measureInterval(cyc);
    checkOutput("ign_w2", cyc, 99);
    measureInterval(cyc);
    checkOutput("ign_w3", cyc, 150);
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; start = 1'b0;
    checkOutput("abt_busy", busy, 0);
    checkOutput("abt_done", done, 0);
    checkOutput("abt_level", data_out, 1);
    checkOutput("abt_pulses", pulses_sent, 3);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abt_idle_busy", busy, 0);
    checkOutput("abt_idle_done", done, 0);
    checkOutput("abt_idle_level", data_out, 1);

    $display("[TB] reset mid-run");
    applyStimulus();
    repeat (30) @(posedge clk);
    #1;
    checkOutput("mr_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("mr_data", data_out, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_pulses", pulses_sent, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
